// File: rtl/lc3_pkg.sv
// Shared LC-3 writeback definitions: result source codes, condition-code
// constants and the queued result record.
package lc3_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC   = 2'd2,
    WB_NONE = 2'd3
  } wb_src_e;

  localparam logic [2:0] NZP_N = 3'b100;
  localparam logic [2:0] NZP_Z = 3'b010;
  localparam logic [2:0] NZP_P = 3'b001;

  typedef struct packed {
    logic [2:0]        dr;
    logic [DATA_W-1:0] data;
    logic              we;
    logic              setcc;
  } wb_entry_t;

  // One-hot condition code for a result value; sign bit takes priority.
  function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] value);
    if (value[DATA_W-1]) begin
      return NZP_N;
    end else if (value == '0) begin
      return NZP_Z;
    end else begin
      return NZP_P;
    end
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order result queue for the writeback stage. Entries and their valid
// bits are exported so the parent can see every in-flight destination.
import lc3_pkg::*;

module wb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  wb_entry_t i_push_data,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output logic      o_empty,
  output logic      o_full,
  output wb_entry_t o_entries [DEPTH],
  output logic [DEPTH-1:0] o_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wb_entry_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [DEPTH-1:0] r_valid;

  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage is not reset; r_valid alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr          <= r_wr_ptr + 1'b1;
        r_valid[r_wr_ptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr          <= r_rd_ptr + 1'b1;
        r_valid[r_rd_ptr] <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head    = r_mem[r_rd_ptr];
  assign o_entries = r_mem;
  assign o_valid   = r_valid;

endmodule

// File: rtl/lc3_writeback.sv
// LC-3 writeback stage: queues completed results, retires one per cycle
// into the register file, tracks NZP and exports a pending-write bitmap.
import lc3_pkg::*;

module lc3_writeback #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [1:0]       wb_src,
  input  logic [2:0]       wb_dr,
  input  logic [WIDTH-1:0] wb_alu,
  input  logic [WIDTH-1:0] wb_mem,
  input  logic [WIDTH-1:0] wb_pc,
  input  logic             wb_setcc,
  input  logic             wr_stall,
  output logic             reg_write_en,
  output logic [2:0]       DR,
  output logic [WIDTH-1:0] write_data,
  output logic [2:0]       nzp,
  output logic [7:0]       pending
);

  logic [WIDTH-1:0] w_src_data;
  wb_entry_t        w_in;
  wb_entry_t        w_head;
  wb_entry_t        w_entries [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [2:0]       r_nzp;

  always_comb begin
    w_src_data = '0;
    case (wb_src)
      WB_ALU:  w_src_data = wb_alu;
      WB_MEM:  w_src_data = wb_mem;
      WB_PC:   w_src_data = wb_pc;
      default: w_src_data = '0;
    endcase
  end

  // NONE results still occupy a slot so retirement order matches issue order.
  always_comb begin
    w_in.dr    = wb_dr;
    w_in.data  = w_src_data;
    w_in.we    = (wb_src != WB_NONE);
    w_in.setcc = wb_setcc && (wb_src != WB_NONE);
  end

  // Ready depends only on the registered fill level, never on wr_stall.
  assign wb_ready = !w_full;
  assign w_push   = wb_valid && wb_ready;
  assign w_pop    = !w_empty && !wr_stall;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_in),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_entries   (w_entries),
    .o_valid     (w_valid)
  );

  assign reg_write_en = w_pop && w_head.we;
  assign DR           = reg_write_en ? w_head.dr : 3'd0;
  assign write_data   = reg_write_en ? w_head.data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nzp <= NZP_Z;
    end else if (w_pop && w_head.setcc) begin
      r_nzp <= nzp_of(w_head.data);
    end
  end

  assign nzp = r_nzp;

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && w_entries[i].we) begin
        pending[w_entries[i].dr] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lc3_writeback.sv
// Directed bench for lc3_writeback with hand-computed expected values.
module tb_lc3_writeback;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [1:0]  wb_src;
  logic [2:0]  wb_dr;
  logic [15:0] wb_alu;
  logic [15:0] wb_mem;
  logic [15:0] wb_pc;
  logic        wb_setcc;
  logic        wr_stall;
  logic        reg_write_en;
  logic [2:0]  DR;
  logic [15:0] write_data;
  logic [2:0]  nzp;
  logic [7:0]  pending;

  int checkCount;
  int errorCount;

  lc3_writeback #(
    .DEPTH (2),
    .WIDTH (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_src       (wb_src),
    .wb_dr        (wb_dr),
    .wb_alu       (wb_alu),
    .wb_mem       (wb_mem),
    .wb_pc        (wb_pc),
    .wb_setcc     (wb_setcc),
    .wr_stall     (wr_stall),
    .reg_write_en (reg_write_en),
    .DR           (DR),
    .write_data   (write_data),
    .nzp          (nzp),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one result offer; settles combinational outputs before returning.
  task automatic applyStimulus(input logic valid, input logic [1:0] src,
                               input logic [2:0] dr, input logic [15:0] alu,
                               input logic [15:0] mem, input logic [15:0] pc,
                               input logic setcc, input logic stall);
    wb_valid = valid;
    wb_src   = src;
    wb_dr    = dr;
    wb_alu   = alu;
    wb_mem   = mem;
    wb_pc    = pc;
    wb_setcc = setcc;
    wr_stall = stall;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkPort(input string tag, input logic en,
                           input logic [2:0] dr, input logic [15:0] data);
    checkOutput({tag, "_we"},   {31'd0, reg_write_en}, {31'd0, en});
    checkOutput({tag, "_dr"},   {29'd0, DR},           {29'd0, dr});
    checkOutput({tag, "_data"}, {16'd0, write_data},   {16'd0, data});
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_ready", {31'd0, wb_ready}, 32'd1);
    checkPort("rst", 1'b0, 3'd0, 16'h0000);
    checkOutput("rst_nzp", {29'd0, nzp}, 32'h2);
    checkOutput("rst_pending", {24'd0, pending}, 32'h00);

    // Single ALU result to R3, negative value
    applyStimulus(1'b1, 2'd0, 3'd3, 16'h8001, 16'h1111, 16'h2222, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkPort("alu1", 1'b1, 3'd3, 16'h8001);
    checkOutput("alu1_pend", {24'd0, pending}, 32'h08);
    tick();
    checkOutput("alu1_nzp", {29'd0, nzp}, 32'h4);
    checkOutput("alu1_pend_clr", {24'd0, pending}, 32'h00);
    checkPort("alu1_idle", 1'b0, 3'd0, 16'h0000);

    // Back-to-back MEM zero to R1 then PC link to R7 without setcc
    applyStimulus(1'b1, 2'd1, 3'd1, 16'h1234, 16'h0000, 16'h5555, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd2, 3'd7, 16'h1234, 16'h4444, 16'h3005, 1'b0, 1'b0);
    checkPort("mem", 1'b1, 3'd1, 16'h0000);
    tick();
    applyStimulus(1'b0, 2'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkPort("pc", 1'b1, 3'd7, 16'h3005);
    checkOutput("mem_nzp", {29'd0, nzp}, 32'h2);
    tick();
    checkOutput("pc_nzp", {29'd0, nzp}, 32'h2);
    checkPort("pc_idle", 1'b0, 3'd0, 16'h0000);

    // Stall fills the queue; third offer waits until a slot frees
    applyStimulus(1'b1, 2'd0, 3'd4, 16'h0004, 16'h0, 16'h0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 2'd0, 3'd5, 16'h0005, 16'h0, 16'h0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 2'd0, 3'd6, 16'h7FFF, 16'h0, 16'h0, 1'b1, 1'b1);
    checkOutput("full_ready", {31'd0, wb_ready}, 32'd0);
    checkOutput("full_pend", {24'd0, pending}, 32'h30);
    checkPort("full_stall", 1'b0, 3'd0, 16'h0000);
    tick();
    checkOutput("full_ready2", {31'd0, wb_ready}, 32'd0);
    checkOutput("full_pend2", {24'd0, pending}, 32'h30);
    applyStimulus(1'b1, 2'd0, 3'd6, 16'h7FFF, 16'h0, 16'h0, 1'b1, 1'b0);
    checkPort("rel_r4", 1'b1, 3'd4, 16'h0004);
    checkOutput("rel_ready", {31'd0, wb_ready}, 32'd0);
    tick();
    checkPort("rel_r5", 1'b1, 3'd5, 16'h0005);
    checkOutput("rel_ready2", {31'd0, wb_ready}, 32'd1);
    checkOutput("rel_nzp", {29'd0, nzp}, 32'h1);
    checkOutput("rel_pend", {24'd0, pending}, 32'h20);
    tick();
    applyStimulus(1'b0, 2'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkPort("rel_r6", 1'b1, 3'd6, 16'h7FFF);
    checkOutput("rel_pend2", {24'd0, pending}, 32'h40);
    tick();
    checkPort("rel_drain", 1'b0, 3'd0, 16'h0000);
    checkOutput("rel_pend3", {24'd0, pending}, 32'h00);
    checkOutput("rel_nzp2", {29'd0, nzp}, 32'h1);

    // NONE entry between two ALU writes to R2
    applyStimulus(1'b1, 2'd0, 3'd2, 16'hFFFF, 16'h0, 16'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd3, 3'd2, 16'h0000, 16'h0, 16'h0, 1'b1, 1'b0);
    checkPort("none_a", 1'b1, 3'd2, 16'hFFFF);
    checkOutput("none_a_pend", {24'd0, pending}, 32'h04);
    tick();
    applyStimulus(1'b1, 2'd0, 3'd2, 16'h0001, 16'h0, 16'h0, 1'b1, 1'b1);
    checkOutput("none_a_nzp", {29'd0, nzp}, 32'h4);
    tick();
    applyStimulus(1'b0, 2'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkPort("none_head", 1'b0, 3'd0, 16'h0000);
    checkOutput("none_pend", {24'd0, pending}, 32'h04);
    tick();
    checkPort("none_b", 1'b1, 3'd2, 16'h0001);
    checkOutput("none_b_pend", {24'd0, pending}, 32'h04);
    checkOutput("none_nzp", {29'd0, nzp}, 32'h4);
    tick();
    checkOutput("none_b_pend2", {24'd0, pending}, 32'h00);
    checkOutput("none_b_nzp", {29'd0, nzp}, 32'h1);
    checkPort("none_idle", 1'b0, 3'd0, 16'h0000);

    // Reset with two entries queued discards them
    applyStimulus(1'b1, 2'd0, 3'd3, 16'h1111, 16'h0, 16'h0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 2'd0, 3'd4, 16'h2222, 16'h0, 16'h0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("prerst_pend", {24'd0, pending}, 32'h18);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 2'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkOutput("mrst_pend", {24'd0, pending}, 32'h00);
    checkOutput("mrst_nzp", {29'd0, nzp}, 32'h2);
    checkOutput("mrst_ready", {31'd0, wb_ready}, 32'd1);
    checkPort("mrst", 1'b0, 3'd0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("mrst_nowrite", {31'd0, reg_write_en}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/lc3_writeback.md
# lc3_writeback

Writeback stage of the LC-3 datapath and the sole driver of the register file write port (`reg_write_en`, `DR`, `write_data`). It accepts completed instruction results from execute/memory over a valid/ready handshake, selects the result source, and buffers results in a small in-order queue. It retires one result per cycle into the register file and maintains the NZP condition-code register. It also exports a per-register pending-write bitmap for decode hazard checks.

## Interface

Parameters:
- `DEPTH`, 2: result queue entries; power of two, ≥2.
- `WIDTH`, 16: data width.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `wb_valid`  in  1  upstream offers a result this cycle.
- `wb_ready`  out  1  block can accept a result; high when queue count < DEPTH.
- `wb_src`  in  2  result source: 0 ALU, 1 MEM, 2 PC (link), 3 NONE (no register write).
- `wb_dr`  in  3  destination register.
- `wb_alu`  in  WIDTH  ALU result.
- `wb_mem`  in  WIDTH  memory load data.
- `wb_pc`  in  WIDTH  incremented PC, used for JSR/JSRR/TRAP link into R7.
- `wb_setcc`  in  1  result updates NZP.
- `wr_stall`  in  1  register file write port unavailable this cycle (debug/monitor access).
- `reg_write_en`  out  1  to register file.
- `DR`  out  3  to register file.
- `write_data`  out  WIDTH  to register file.
- `nzp`  out  3  condition codes {N,Z,P}.
- `pending`  out  8  bit r set while any queued entry will write Rr.

## Operation

- Accept: `wb_valid && wb_ready` at a rising edge enqueues {dr, data, we, setcc}.
  - data = mux of `wb_alu`/`wb_mem`/`wb_pc` by `wb_src`, captured at enqueue; later changes on the inputs are ignored.
  - we = (`wb_src` != NONE).
  - setcc = `wb_setcc && we`.
- NONE entries are still enqueued to preserve order; they drain with no write and no NZP change.
- Pop: when the queue is non-empty and `wr_stall` is low, the head entry pops at the rising edge.
- Write port (combinational from head): `reg_write_en` = non-empty && !`wr_stall` && head.we; `DR` = head.dr; `write_data` = head.data. When `reg_write_en` is low, `DR` and `write_data` are 0.
- NZP: on a pop with head.setcc, `nzp` updates from head.data. 100 if bit 15 is set, 010 if the data is zero, 001 otherwise. Exactly one bit is ever set.
- Pending: bit r is the OR over valid entries of (we && dr==r); it is combinational from queue contents.
- Simultaneous push and pop: both occur and the count is unchanged. When the queue is full, `wb_ready` stays low even if a pop occurs that cycle. There is no combinational path from `wr_stall` to `wb_ready`.
- Pointers wrap modulo DEPTH. The count ranges 0..DEPTH and never over- or underflows.
- `wb_valid` while `wb_ready` is low: nothing is enqueued. Upstream holds its inputs.
- Reset, including mid-operation: the queue is flushed and in-flight results are discarded. `wb_ready` = 1, `reg_write_en` = 0, `DR` = 0, `write_data` = 0, `nzp` = 010, `pending` = 0.

## Timing

- Latency: a result accepted at edge T appears on the write port during cycle T→T+1 (if the queue was empty and there is no stall). The register file commits it at edge T+1.
- `nzp` and `pending` reflect the retirement at edge T+1.
- Throughput: 1 result/cycle sustained while `wr_stall` is low.
- Each cycle of `wr_stall` delays retirement by one cycle. After DEPTH accepts without a pop, `wb_ready` drops on the next cycle.
- `pending` bits for a register set in the cycle after accept and clear in the cycle after the last queued write to that register pops.

## Structure

- Shared package `lc3_pkg`:
  - source codes `WB_ALU`/`WB_MEM`/`WB_PC`/`WB_NONE`
  - NZP reset constant `NZP_Z` = 3'b010
  - `wb_entry_t` struct {dr[2:0], data[15:0], we, setcc}
- Sub-module `wb_fifo`: generic synchronous FIFO of `wb_entry_t`, parameterised by DEPTH, exposing its entry array and valid bits so the parent can build `pending`.
- Top level contains the source mux, write-port drive, NZP register and pending reduction.

## Test plan

- Reset, then single ALU result (dr=3, alu=16'h8001, setcc=1): the next cycle shows `reg_write_en`=1, `DR`=3, `write_data`=8001. After that edge `nzp`=100 and `pending`=0.
- Back-to-back MEM 16'h0000→R1 (setcc) then PC 16'h3005→R7 (setcc=0) with no stall: consecutive writes R1=0000 then R7=3005; `nzp`=010 and unchanged by the second write.
- Hold `wr_stall`=1 and offer 3 results with DEPTH=2: first two accepted, `wb_ready` drops, `pending`=bits of both DRs, `reg_write_en`=0. Release the stall: in-order writes and the third is accepted.
- Full queue with simultaneous pop and `wb_valid`: the pop occurs, no accept that cycle, accepted next cycle. Checks that there is no loss and no duplicate.
- NONE source (store) between two ALU writes to R2: no write cycle for NONE, `nzp` unaffected, `pending[2]` stays set until the second R2 write retires.
- Assert `rst` with 2 entries queued: next cycle the queue is empty, `pending`=0, `nzp`=010, no subsequent register write.
